multi_lane_hit_judge: RTL and testbench
=======================================

// Module: multi_lane_hit_judge
// PURPOSE
//  Parametrised successor to the single-lane click detector. Judges key presses for LANES
//  independent lanes against the note nearest the hit marker as PERFECT/GOOD/MISS. Also
//  accumulates score and combo. Sits between the key synchroniser and the note scroller;
//  the scroller supplies per-lane note distance, and the renderer reads score and combo.
// PARAMETERS
//  LANES        4   number of key/note lanes
//  DIST_W       8   width of signed note distance (pixels from marker, two's complement)
//  PERFECT_WIN  2   |dist| <= PERFECT_WIN -> PERFECT
//  GOOD_WIN     6   |dist| <= GOOD_WIN -> GOOD (must be >= PERFECT_WIN)
//  SCORE_W      16  score counter width
//  COMBO_W      8   combo counters width
//  GHOST_MISS   1   1: press with no note counts as MISS; 0: ignored
// PORTS
//  clk           in   1              system clock, all logic on posedge
//  resetb        in   1              synchronous reset, ACTIVE-HIGH (1 = reset)
//  key           in   LANES          synchronised key levels, 1 = pressed
//  note_valid    in   LANES          lane has a note within scroll range
//  note_dist     in   LANES*DIST_W   signed distance of nearest note, lane i at [i*DIST_W +: DIST_W]
//  note_expired  in   LANES          1-cycle pulse: note scrolled past marker unpressed
//  hit           out  LANES          1-cycle pulse: PERFECT or GOOD judged
//  miss          out  LANES          1-cycle pulse: MISS judged (bad press, ghost, expiry)
//  judge         out  LANES*2        code valid with hit/miss: 0 NONE,1 PERFECT,2 GOOD,3 MISS
//  note_consume  out  LANES          1-cycle pulse with hit: scroller deletes that note
//  score         out  SCORE_W        running score
//  combo         out  COMBO_W        current consecutive-hit count
//  max_combo     out  COMBO_W        best combo since reset
// BEHAVIOUR
//  - Reset (resetb=1 at posedge): all outputs 0, all lanes IDLE, key history cleared.
//  - One clock and one reset domain. Synchronous reset overrides everything, including
//    any judgement in flight. No pulse is emitted in the cycle after reset.
//  - Per-lane FSM: IDLE -> JUDGE -> WAIT_REL -> IDLE.
//    IDLE: the lane registers key as key_q. On key & ~key_q (rising edge) in cycle N,
//      capture note_valid and note_dist, then go to JUDGE.
//    JUDGE (cycle N+1): evaluate |dist|:
//      valid & <= PERFECT_WIN -> PERFECT; valid & <= GOOD_WIN -> GOOD; valid & > GOOD_WIN -> MISS;
//      no note -> MISS if GHOST_MISS, else NONE with no pulse.
//      hit/miss/judge/note_consume are asserted for exactly cycle N+1. Next state is WAIT_REL.
//    WAIT_REL: hold until key==0, then IDLE. Holding the key never re-triggers.
//  - |dist| is computed in DIST_W+1 bits, so the most negative distance has no overflow.
//  - note_expired in any state -> miss=1, judge=MISS the next cycle; note_consume stays 0.
//    If note_expired coincides with a capturing edge in the same cycle, the press owns the
//    note and the expiry is dropped. If expiry lands in the JUDGE cycle, the judgement is
//    output and the expiry is reported one cycle later.
//  - Score/combo update one cycle after the pulses (N+2), summing all lanes judged that cycle:
//    PERFECT +3, GOOD +1 each; combo += hit count. Any miss that cycle forces combo to 0,
//    and misses take priority over simultaneous hits.
//  - score and combo saturate at all-ones (no wrap). max_combo = max(max_combo, new combo).
//  - Lanes are fully independent; any number of lanes may judge in the same cycle.
// STRUCTURE
//  - Shared package hit_judge_pkg: JUDGE_NONE/PERFECT/GOOD/MISS codes (2b),
//    lane state encodings, score weights PTS_PERFECT=3, PTS_GOOD=1.
//  - Sub-module hit_judge_lane (one per lane, generate loop) holds edge detect, FSM,
//    window compare, and expiry handling. The top holds only the score/combo adder tree and
//    saturation logic.
// TESTING
//  1 Reset: hold resetb=1 for 3 cycles with keys toggling -> all outputs 0, no pulses.
//  2 Lane0 rising edge, note_valid=1, dist=-2 -> N+1 hit[0]=1, judge=PERFECT, consume=1;
//    N+2 score=3, combo=1.
//  3 Lane1 dist=+5 -> GOOD, score+1. Then lane1 dist=+7 -> miss[1]=1, judge=MISS,
//    consume=0, combo=0.
//  4 Key held high for 20 cycles after one press -> exactly one judgement. Ghost press with
//    note_valid=0: GHOST_MISS=1 -> miss; GHOST_MISS=0 -> no pulse.
//  5 All 4 lanes press same cycle, dists 0,1,4,-9 -> 2 PERFECT, 1 GOOD, 1 MISS;
//    score+=7, combo=0.
//  6 Saturation and timing: preload to 32-combo / near-max score -> combo and score clamp at
//    all-ones. note_expired with a press edge on the same lane in the same cycle -> press
//    judged, no extra miss. resetb asserted in the JUDGE cycle -> no pulse.

Source files
------------

// File: rtl/hit_judge_pkg.sv
// hit_judge_pkg: shared judgement codes, lane state encodings and score weights
package hit_judge_pkg;
    localparam logic [1:0] JUDGE_NONE    = 2'd0;
    localparam logic [1:0] JUDGE_PERFECT = 2'd1;
    localparam logic [1:0] JUDGE_GOOD    = 2'd2;
    localparam logic [1:0] JUDGE_MISS    = 2'd3;
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_JUDGE      = 2'd1;
    localparam logic [1:0] ST_WAIT_REL   = 2'd2;
    localparam int PTS_PERFECT = 3;
    localparam int PTS_GOOD    = 1;
endpackage

// File: rtl/hit_judge_lane.sv
// hit_judge_lane: per-lane press edge detect, judgement window compare and expiry reporting
module hit_judge_lane
    import hit_judge_pkg::*;
#(
    parameter int DIST_W      = 8,
    parameter int PERFECT_WIN = 2,
    parameter int GOOD_WIN    = 6,
    parameter int GHOST_MISS  = 1
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              key,
    input  logic              note_valid,
    input  logic [DIST_W-1:0] note_dist,
    input  logic              note_expired,
    output logic              hit,
    output logic              miss,
    output logic [1:0]        judge,
    output logic              note_consume
);
    logic [1:0]        state;
    logic              key_q;
    logic              cap_valid;
    logic [DIST_W-1:0] cap_dist;
    logic              exp_q;
    logic              capture;
    logic [DIST_W:0]   mag;
    logic [1:0]        win_code;
    assign capture = (state == ST_IDLE) && key && !key_q;
    // a press owns the note, so an expiry arriving with the capturing edge is dropped
    always_ff @(posedge clk) begin
        if (resetb) begin
            state     <= ST_IDLE;
            key_q     <= 1'b0;
            cap_valid <= 1'b0;
            cap_dist  <= '0;
            exp_q     <= 1'b0;
        end else begin
            key_q <= key;
            exp_q <= note_expired && !capture;
            if (capture) begin
                cap_valid <= note_valid;
                cap_dist  <= note_dist;
            end
            state <= capture ? ST_JUDGE :
                     (state == ST_JUDGE) ? ST_WAIT_REL :
                     (state == ST_WAIT_REL && !key) ? ST_IDLE : state;
        end
    end
    // magnitude is one bit wider so the most negative distance cannot overflow
    always_comb begin
        mag      = cap_dist[DIST_W-1] ? -{cap_dist[DIST_W-1], cap_dist} : {1'b0, cap_dist};
        win_code = !cap_valid ? ((GHOST_MISS != 0) ? JUDGE_MISS : JUDGE_NONE) :
                   (mag <= (DIST_W+1)'(PERFECT_WIN)) ? JUDGE_PERFECT :
                   (mag <= (DIST_W+1)'(GOOD_WIN)) ? JUDGE_GOOD : JUDGE_MISS;
        judge    = resetb ? JUDGE_NONE :
                   (state == ST_JUDGE) ? win_code :
                   exp_q ? JUDGE_MISS : JUDGE_NONE;
        hit          = (judge == JUDGE_PERFECT) || (judge == JUDGE_GOOD);
        miss         = judge == JUDGE_MISS;
        note_consume = hit;
    end
endmodule

// File: rtl/multi_lane_hit_judge.sv
// multi_lane_hit_judge: independent lane judges plus shared saturating score/combo tally
module multi_lane_hit_judge
    import hit_judge_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int DIST_W      = 8,
    parameter int PERFECT_WIN = 2,
    parameter int GOOD_WIN    = 6,
    parameter int SCORE_W     = 16,
    parameter int COMBO_W     = 8,
    parameter int GHOST_MISS  = 1
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic [LANES-1:0]        key,
    input  logic [LANES-1:0]        note_valid,
    input  logic [LANES*DIST_W-1:0] note_dist,
    input  logic [LANES-1:0]        note_expired,
    output logic [LANES-1:0]        hit,
    output logic [LANES-1:0]        miss,
    output logic [LANES*2-1:0]      judge,
    output logic [LANES-1:0]        note_consume,
    output logic [SCORE_W-1:0]      score,
    output logic [COMBO_W-1:0]      combo,
    output logic [COMBO_W-1:0]      max_combo
);
    localparam int PTS_W = $clog2(PTS_PERFECT*LANES+1);
    localparam int CNT_W = $clog2(LANES+1);
    logic [PTS_W-1:0]   pts;
    logic [CNT_W-1:0]   hits;
    logic [SCORE_W:0]   score_sum;
    logic [COMBO_W:0]   combo_sum;
    logic [SCORE_W-1:0] score_next;
    logic [COMBO_W-1:0] combo_next;
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        hit_judge_lane #(
            .DIST_W(DIST_W), .PERFECT_WIN(PERFECT_WIN),
            .GOOD_WIN(GOOD_WIN), .GHOST_MISS(GHOST_MISS)
        ) u_lane (
            .clk(clk), .resetb(resetb), .key(key[g]), .note_valid(note_valid[g]),
            .note_dist(note_dist[g*DIST_W +: DIST_W]), .note_expired(note_expired[g]),
            .hit(hit[g]), .miss(miss[g]), .judge(judge[2*g +: 2]),
            .note_consume(note_consume[g])
        );
    end
    // sum this cycle's judgements across lanes; any miss breaks the combo outright
    always_comb begin
        pts  = '0;
        hits = '0;
        for (int i = 0; i < LANES; i++) begin
            pts  = pts + ((judge[2*i +: 2] == JUDGE_PERFECT) ? PTS_W'(PTS_PERFECT) :
                          (judge[2*i +: 2] == JUDGE_GOOD) ? PTS_W'(PTS_GOOD) : PTS_W'(0));
            hits = hits + CNT_W'(hit[i]);
        end
        score_sum  = {1'b0, score} + (SCORE_W+1)'(pts);
        combo_sum  = {1'b0, combo} + (COMBO_W+1)'(hits);
        score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        combo_next = (|miss) ? '0 : combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
    end
    // tally registers lag the lane pulses by one cycle
    always_ff @(posedge clk) begin
        if (resetb) begin
            score     <= '0;
            combo     <= '0;
            max_combo <= '0;
        end else begin
            score     <= score_next;
            combo     <= combo_next;
            max_combo <= (combo_next > max_combo) ? combo_next : max_combo;
        end
    end
endmodule

// File: tb/tb_multi_lane_hit_judge.sv
// tb_multi_lane_hit_judge: directed vectors against default and small-counter/no-ghost instances
module tb_multi_lane_hit_judge;
    logic        clk = 1'b0;
    logic        resetb = 1'b1;
    logic [3:0]  key = '0;
    logic [3:0]  note_valid = '0;
    logic [31:0] note_dist = '0;
    logic [3:0]  note_expired = '0;
    logic [3:0]  hit, miss, note_consume;
    logic [7:0]  judge;
    logic [15:0] score;
    logic [7:0]  combo, max_combo;
    logic [3:0]  hit2, miss2, consume2;
    logic [7:0]  judge2;
    logic [6:0]  score2;
    logic [4:0]  combo2, max2;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    multi_lane_hit_judge dut (
        .clk(clk), .resetb(resetb), .key(key), .note_valid(note_valid),
        .note_dist(note_dist), .note_expired(note_expired), .hit(hit), .miss(miss),
        .judge(judge), .note_consume(note_consume), .score(score), .combo(combo),
        .max_combo(max_combo)
    );

    multi_lane_hit_judge #(.SCORE_W(7), .COMBO_W(5), .GHOST_MISS(0)) dut2 (
        .clk(clk), .resetb(resetb), .key(key), .note_valid(note_valid),
        .note_dist(note_dist), .note_expired(note_expired), .hit(hit2), .miss(miss2),
        .judge(judge2), .note_consume(consume2), .score(score2), .combo(combo2),
        .max_combo(max2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] k, input logic [3:0] v, input logic [31:0] d);
        @(negedge clk);
        key = k;
        note_valid = v;
        note_dist = d;
        @(negedge clk);
    endtask

    task automatic rel;
        key = '0;
        note_valid = '0;
        @(negedge clk);
    endtask

    task automatic tally(input string tag, input logic [15:0] s, input logic [7:0] c, input logic [7:0] m);
        chk({tag, "_score"}, score, s);
        chk({tag, "_combo"}, combo, c);
        chk({tag, "_max"}, max_combo, m);
    endtask

    initial begin
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("rst_pulse", {hit, miss, note_consume, judge}, 0);
            chk("rst_tally", {score, combo, max_combo}, 0);
            chk("rst_pulse2", {hit2, miss2}, 0);
            key = key ^ 4'hF;
        end
        @(negedge clk);
        key = '0;
        resetb = 1'b0;
        @(negedge clk);
        chk("post_rst_pulse", {hit, miss, judge}, 0);

        press(4'h1, 4'h1, 32'h0000_00FE);
        chk("perf_hit", hit, 4'h1);
        chk("perf_judge", judge, 8'h01);
        chk("perf_consume", note_consume, 4'h1);
        chk("perf_miss", miss, 4'h0);
        rel;
        tally("perf", 16'd3, 8'd1, 8'd1);

        press(4'h2, 4'h2, 32'h0000_0500);
        chk("good_hit", hit, 4'h2);
        chk("good_judge", judge, 8'h08);
        rel;
        tally("good", 16'd4, 8'd2, 8'd2);

        press(4'h2, 4'h2, 32'h0000_0700);
        chk("far_miss", miss, 4'h2);
        chk("far_judge", judge, 8'h0C);
        chk("far_consume", note_consume, 4'h0);
        chk("far_hit", hit, 4'h0);
        rel;
        tally("far", 16'd4, 8'd0, 8'd2);

        press(4'h2, 4'h2, 32'h0000_8000);
        chk("minneg_judge", judge, 8'h0C);
        rel;

        press(4'h4, 4'h4, 32'h0000_0000);
        chk("hold_first", hit, 4'h4);
        chk("hold_judge", judge, 8'h10);
        repeat (20) begin
            @(negedge clk);
            chk("hold_quiet", {hit, miss}, 0);
        end
        rel;
        tally("hold", 16'd7, 8'd1, 8'd2);

        press(4'h8, 4'h0, 32'h0000_0000);
        chk("ghost_miss", miss, 4'h8);
        chk("ghost_judge", judge, 8'hC0);
        chk("ghost_consume", note_consume, 4'h0);
        chk("ghost_off", {hit2, miss2, judge2}, 0);
        rel;
        tally("ghost", 16'd7, 8'd0, 8'd2);

        press(4'hF, 4'hF, 32'hF704_0100);
        chk("quad_hit", hit, 4'h7);
        chk("quad_miss", miss, 4'h8);
        chk("quad_judge", judge, 8'hE5);
        chk("quad_consume", note_consume, 4'h7);
        rel;
        tally("quad", 16'd14, 8'd0, 8'd2);

        for (int r = 0; r < 64; r++) begin
            press(4'hF, 4'hF, 32'h0000_0000);
            chk("sat_hit", hit, 4'hF);
            chk("sat_judge", judge, 8'h55);
            rel;
            if (r == 9) begin
                chk("small_score", score2, 7'd127);
                chk("small_combo", combo2, 5'd31);
                chk("small_max", max2, 5'd31);
                tally("r10", 16'd134, 8'd40, 8'd40);
            end
        end
        tally("sat", 16'd782, 8'd255, 8'd255);

        @(negedge clk);
        key = 4'h1;
        note_valid = 4'h1;
        note_dist = '0;
        note_expired = 4'h1;
        @(negedge clk);
        note_expired = '0;
        chk("coinc_hit", hit, 4'h1);
        chk("coinc_miss", miss, 4'h0);
        rel;
        chk("coinc_nomiss", miss, 4'h0);
        tally("coinc", 16'd785, 8'd255, 8'd255);

        @(negedge clk);
        note_expired = 4'h2;
        @(negedge clk);
        note_expired = '0;
        chk("exp_miss", miss, 4'h2);
        chk("exp_judge", judge, 8'h0C);
        chk("exp_consume", note_consume, 4'h0);
        @(negedge clk);
        tally("exp", 16'd785, 8'd0, 8'd255);

        press(4'h4, 4'h4, 32'h0000_0000);
        note_expired = 4'h4;
        chk("jexp_hit", hit, 4'h4);
        chk("jexp_miss", miss, 4'h0);
        key = '0;
        note_valid = '0;
        @(negedge clk);
        note_expired = '0;
        chk("jexp_late_miss", miss, 4'h4);
        chk("jexp_late_judge", judge, 8'h30);
        chk("jexp_late_hit", hit, 4'h0);
        @(negedge clk);
        tally("jexp", 16'd788, 8'd0, 8'd255);

        press(4'h8, 4'h8, 32'h0000_0000);
        resetb = 1'b1;
        #1;
        chk("rst_judge_pulse", {hit, miss, note_consume, judge}, 0);
        @(negedge clk);
        tally("rst_judge", 16'd0, 8'd0, 8'd0);
        key = '0;
        note_valid = '0;
        resetb = 1'b0;
        @(negedge clk);
        chk("rst_after_pulse", {hit, miss, judge}, 0);
        @(negedge clk);
        tally("rst_after", 16'd0, 8'd0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
